// File: rtl/alu_writeback_if.sv
// Upstream ALU-result bus and register-file write bus of the ALU writeback stage.
// The master side is the surrounding pipeline; the slave side is the stage itself.
interface alu_writeback_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            opsel;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0] rr_val;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output in_valid, opsel, rd_addr, rd_val, rr_val, alu_out, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, opsel, rd_addr, rd_val, rr_val, alu_out, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/alu_writeback.sv
// One-entry pipeline register after the ALU: computes AVR-style flags, owns SREG and
// issues the result to the register-file write port over valid/ready.
module alu_writeback #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_writeback_if.slave        bus,
  output logic [7:0]            sreg,
  output logic                  op_err
);

  localparam logic [7:0] OPSEL_NONE = 8'h00;
  localparam logic [7:0] OPSEL_ADD  = 8'h01;
  localparam logic [7:0] OPSEL_SUB  = 8'h02;
  localparam logic [7:0] OPSEL_AND  = 8'h03;
  localparam logic [7:0] OPSEL_OR   = 8'h04;
  localparam logic [7:0] OPSEL_XOR  = 8'h05;
  localparam logic [7:0] OPSEL_NEG  = 8'h06;

  localparam int M = DATA_WIDTH - 1;

  typedef enum logic { ST_EMPTY = 1'b0, ST_FULL = 1'b1 } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_LOGIC, OP_NEG, OP_BAD
  } op_kind_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [7:0]            sreg_q, sreg_d;
  logic                  op_err_q, op_err_d;

  op_kind_t op_kind;
  logic     accept, transfer;
  logic     rd_m, rr_m, r_m;
  logic     flag_c, flag_h, flag_v, flag_n, flag_z;
  logic     update_flags;
  logic [7:0] sreg_new;

  assign bus.in_ready = (state_q == ST_EMPTY) || bus.wb_ready;
  assign bus.wb_valid = (state_q == ST_FULL);
  assign bus.wb_addr  = wb_addr_q;
  assign bus.wb_data  = wb_data_q;
  assign sreg         = sreg_q;
  assign op_err       = op_err_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign transfer = bus.wb_valid && bus.wb_ready;

  assign rd_m = bus.rd_val[M];
  assign rr_m = bus.rr_val[M];
  assign r_m  = bus.alu_out[M];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    op_kind = OP_BAD;
    case (bus.opsel)
      OPSEL_NONE: op_kind = OP_NONE;
      OPSEL_ADD:  op_kind = OP_ADD;
      OPSEL_SUB:  op_kind = OP_SUB;
      OPSEL_AND,
      OPSEL_OR,
      OPSEL_XOR:  op_kind = OP_LOGIC;
      OPSEL_NEG:  op_kind = OP_NEG;
      default:    op_kind = OP_BAD;
    endcase
  end

  // Carries come from DATA_WIDTH+1-bit sums; N, Z and V use the ALU's own result.
  always_comb begin
    flag_c       = sreg_q[0];
    flag_h       = sreg_q[5];
    flag_v       = 1'b0;
    flag_n       = r_m;
    flag_z       = (bus.alu_out == '0);
    update_flags = 1'b1;
    case (op_kind)
      OP_ADD: begin
        flag_c = ({1'b0, bus.rd_val} + {1'b0, bus.rr_val}) > {1'b0, {DATA_WIDTH{1'b1}}};
        flag_h = ({1'b0, bus.rd_val[3:0]} + {1'b0, bus.rr_val[3:0]}) > 5'd15;
        flag_v = (rd_m & rr_m & ~r_m) | (~rd_m & ~rr_m & r_m);
      end
      OP_SUB: begin
        flag_c = bus.rr_val > bus.rd_val;
        flag_h = bus.rr_val[3:0] > bus.rd_val[3:0];
        flag_v = (rd_m & ~rr_m & ~r_m) | (~rd_m & rr_m & r_m);
      end
      OP_LOGIC: flag_v = 1'b0;
      OP_NEG:   flag_c = 1'b1;
      default:  update_flags = 1'b0;
    endcase
    sreg_new = update_flags
             ? {sreg_q[7:6], flag_h, flag_n ^ flag_v, flag_v, flag_n, flag_z, flag_c}
             : sreg_q;
  end

  always_comb begin
    state_d   = state_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    sreg_d    = sreg_q;
    op_err_d  = 1'b0;
    if (accept && op_kind == OP_BAD) begin
      // An unknown op is consumed without a write; a coincident transfer still drains.
      op_err_d = 1'b1;
      if (transfer) state_d = ST_EMPTY;
    end else if (accept) begin
      state_d   = ST_FULL;
      wb_addr_d = bus.rd_addr;
      wb_data_d = bus.alu_out;
      sreg_d    = sreg_new;
    end else if (transfer) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= ST_EMPTY;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      sreg_q    <= 8'h00;
      op_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      sreg_q    <= sreg_d;
      op_err_q  <= op_err_d;
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomized bench for alu_writeback: a transaction-level model computes flags with
// integer arithmetic and predicts the write port, SREG and op_err every cycle.
module tb_alu_writeback;
  localparam int W = 8;
  localparam int A = 5;

  localparam logic [7:0] K_NONE = 8'h00;
  localparam logic [7:0] K_ADD  = 8'h01;
  localparam logic [7:0] K_SUB  = 8'h02;
  localparam logic [7:0] K_AND  = 8'h03;
  localparam logic [7:0] K_OR   = 8'h04;
  localparam logic [7:0] K_XOR  = 8'h05;
  localparam logic [7:0] K_NEG  = 8'h06;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sreg;
  logic       op_err;

  alu_writeback_if #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) bus ();

  alu_writeback #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .sreg   (sreg),
    .op_err (op_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit         m_valid = 1'b0;
  logic [A-1:0] m_addr = '0;
  logic [W-1:0] m_data = '0;
  logic [7:0] m_sreg = 8'h00;
  bit         m_err  = 1'b0;
  int         n_xfer = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit is_known(input logic [7:0] op);
    return op <= K_NEG;
  endfunction

  function automatic logic [W-1:0] alu_result(input logic [7:0] op,
                                              input logic [W-1:0] rd, input logic [W-1:0] rr);
    case (op)
      K_ADD:   return rd + rr;
      K_SUB:   return rd - rr;
      K_AND:   return rd & rr;
      K_OR:    return rd | rr;
      K_XOR:   return rd ^ rr;
      K_NEG:   return ~rd;
      K_NONE:  return rr;
      default: return W'($urandom);
    endcase
  endfunction

  // Flags from the arithmetic meaning of each op (signed overflow, unsigned carry/borrow).
  function automatic logic [7:0] ref_sreg(input logic [7:0] op, input logic [W-1:0] rd,
                                          input logic [W-1:0] rr, input logic [W-1:0] r,
                                          input logic [7:0] old);
    int a  = int'(rd);
    int b  = int'(rr);
    int sa = (a >= 128) ? a - 256 : a;
    int sb = (b >= 128) ? b - 256 : b;
    bit c = old[0];
    bit h = old[5];
    bit v = 1'b0;
    bit n, z;
    if (op == K_NONE || !is_known(op)) return old;
    case (op)
      K_ADD: begin
        c = (a + b) > 255;
        h = (a % 16 + b % 16) > 15;
        v = (sa + sb) > 127 || (sa + sb) < -128;
      end
      K_SUB: begin
        c = b > a;
        h = (b % 16) > (a % 16);
        v = (sa - sb) > 127 || (sa - sb) < -128;
      end
      K_NEG:   c = 1'b1;
      default: ;
    endcase
    n = r[W-1];
    z = (r == 0);
    return {old[7:6], h, n ^ v, v, n, z, c};
  endfunction

  // Drives one cycle of stimulus from a negedge, advances the model, checks at the next negedge.
  task automatic step(input bit iv, input logic [7:0] op, input logic [A-1:0] ad,
                      input logic [W-1:0] rd, input logic [W-1:0] rr, input logic [W-1:0] r,
                      input bit wr, input bit rst);
    bit ready, acc, xfer;
    reset        = rst;
    bus.in_valid = iv;
    bus.opsel    = op;
    bus.rd_addr  = ad;
    bus.rd_val   = rd;
    bus.rr_val   = rr;
    bus.alu_out  = r;
    bus.wb_ready = wr;
    #1;
    ready = !m_valid || wr;
    check("in_ready", bus.in_ready, ready);
    acc  = iv && ready && !rst;
    xfer = m_valid && wr && !rst;
    if (rst) begin
      m_valid = 1'b0; m_addr = '0; m_data = '0; m_sreg = 8'h00; m_err = 1'b0;
    end else begin
      m_err = acc && !is_known(op);
      if (xfer) n_xfer++;
      if (acc && is_known(op)) begin
        m_sreg  = ref_sreg(op, rd, rr, r, m_sreg);
        m_valid = 1'b1;
        m_addr  = ad;
        m_data  = r;
      end else if (xfer) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("wb_valid", bus.wb_valid, m_valid);
    check("sreg", sreg, m_sreg);
    check("op_err", op_err, m_err);
    if (m_valid) begin
      check("wb_addr", bus.wb_addr, m_addr);
      check("wb_data", bus.wb_data, m_data);
    end
  endtask

  task automatic idle(input bit wr);
    step(1'b0, K_NONE, '0, '0, '0, '0, wr, 1'b0);
  endtask

  initial begin
    bit           iv, wr, rst, acc, hold;
    logic [7:0]   op;
    logic [A-1:0] ad;
    logic [W-1:0] rd, rr, r;
    int           xfer_before;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.opsel = '0; bus.rd_addr = '0;
    bus.rd_val = '0; bus.rr_val = '0; bus.alu_out = '0; bus.wb_ready = 1'b1;

    step(1'b0, K_NONE, '0, '0, '0, '0, 1'b1, 1'b1);
    step(1'b0, K_NONE, '0, '0, '0, '0, 1'b1, 1'b1);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_wb_addr", bus.wb_addr, 5'd0);
    check("rst_wb_data", bus.wb_data, 8'h00);
    check("rst_sreg", sreg, 8'h00);
    check("rst_op_err", op_err, 1'b0);

    // Directed scenarios with hand-derived results.
    step(1'b1, K_ADD, 5'd3, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0);
    check("t1_wb_valid", bus.wb_valid, 1'b1);
    check("t1_wb_addr", bus.wb_addr, 5'd3);
    check("t1_wb_data", bus.wb_data, 8'h80);
    check("t1_sreg", sreg, 8'h2C);

    step(1'b1, K_SUB, 5'd4, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    check("t2_sreg", sreg, 8'h35);
    check("t2_wb_data", bus.wb_data, 8'hFF);

    step(1'b1, K_AND, 5'd5, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0);
    check("t3_sreg", sreg, 8'h23);

    step(1'b1, K_NONE, 5'd6, 8'h00, 8'h55, 8'h55, 1'b1, 1'b0);
    check("t5_wb_data", bus.wb_data, 8'h55);
    check("t5_sreg", sreg, 8'h23);
    step(1'b1, 8'hEE, 5'd7, 8'h12, 8'h34, 8'h99, 1'b1, 1'b0);
    check("t5_op_err", op_err, 1'b1);
    check("t5_bad_no_write", bus.wb_valid, 1'b0);
    check("t5_bad_sreg", sreg, 8'h23);
    idle(1'b1);
    check("t5_op_err_pulse", op_err, 1'b0);

    step(1'b1, K_ADD, 5'd8, 8'h10, 8'h20, 8'h30, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, K_XOR, 5'd9, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0);
      check("t4_in_ready_low", bus.in_ready, 1'b0);
      check("t4_data_stable", bus.wb_data, 8'h30);
    end
    xfer_before = n_xfer;
    step(1'b1, K_XOR, 5'd9, 8'hAA, 8'h55, 8'hFF, 1'b1, 1'b0);
    check("t4_no_gap_valid", bus.wb_valid, 1'b1);
    check("t4_next_data", bus.wb_data, 8'hFF);
    check("t4_one_transfer", n_xfer - xfer_before, 1);

    step(1'b1, K_OR, 5'd10, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    check("t6_full_before_reset", bus.wb_valid, 1'b1);
    step(1'b1, K_OR, 5'd10, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1);
    check("t6_wb_valid", bus.wb_valid, 1'b0);
    check("t6_sreg", sreg, 8'h00);
    idle(1'b1);
    check("t6_no_write", bus.wb_valid, 1'b0);

    // Random traffic; a stalled request is held unchanged until accepted.
    hold = 1'b0;
    iv = 1'b0; op = K_NONE; ad = '0; rd = '0; rr = '0; r = '0;
    for (int i = 0; i < 800; i++) begin
      wr  = ($urandom % 10) < 7;
      rst = ($urandom % 97) == 0;
      if (!hold) begin
        iv = ($urandom % 10) < 7;
        op = (($urandom % 10) == 0) ? 8'($urandom_range(7, 255)) : 8'($urandom_range(0, 6));
        ad = A'($urandom);
        rd = W'($urandom);
        rr = W'($urandom);
        r  = alu_result(op, rd, rr);
      end
      acc  = iv && (!m_valid || wr);
      hold = iv && !acc && !rst;
      step(iv, op, ad, rd, rr, r, wr, rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
